// File: rtl/ub_pkg.sv
// ---------------------------------------------------------------------------
// ub_pkg
// Types and constants shared by the unified-buffer skew streamer and its
// per-lane delay line.
//   UB_BYTE_W   - width of one lane (one byte of a UB row)
//   ub_state_e  - streamer control FSM states
// ---------------------------------------------------------------------------
package ub_pkg;

  localparam int UB_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } ub_state_e;

endpackage

// File: rtl/ub_skew_line.sv
// ---------------------------------------------------------------------------
// ub_skew_line
// Byte + valid shift register of DEPTH stages for one systolic-array lane.
// The first stage captures the UB read data; the last stage is the lane's
// output register.
//   CLK        in   clock
//   ASYNC_RST  in   asynchronous clear, active-high
//   SYNC_RST   in   synchronous clear, active-high
//   in_vld     in   input byte valid
//   in_data    in   input byte
//   out_vld    out  delayed valid
//   out_data   out  delayed byte (0 whenever out_vld is 0)
// ---------------------------------------------------------------------------
module ub_skew_line
  import ub_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic                 CLK,
  input  logic                 ASYNC_RST,
  input  logic                 SYNC_RST,
  input  logic                 in_vld,
  input  logic [UB_BYTE_W-1:0] in_data,
  output logic                 out_vld,
  output logic [UB_BYTE_W-1:0] out_data
);

  logic [DEPTH-1:0]                vld_p;
  logic [DEPTH-1:0][UB_BYTE_W-1:0] data_p;

  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      vld_p  <= '0;
      data_p <= '0;
    end else if (SYNC_RST) begin
      vld_p  <= '0;
      data_p <= '0;
    end else begin
      // Gating at entry keeps invalid slots zero all the way down the line.
      vld_p[0]  <= in_vld;
      data_p[0] <= in_vld ? in_data : '0;
      for (int k = 1; k < DEPTH; k++) begin
        vld_p[k]  <= vld_p[k-1];
        data_p[k] <= data_p[k-1];
      end
    end
  end

  assign out_vld  = vld_p[DEPTH-1];
  assign out_data = data_p[DEPTH-1];

endmodule

// File: rtl/ub_skew_streamer.sv
// ---------------------------------------------------------------------------
// ub_skew_streamer
// Streams cmd_len consecutive UB rows starting at cmd_addr out of the UB wide
// read port and onto the systolic-array row inputs, with lane i delayed i
// cycles relative to lane 0. One command per run; done pulses after the skew
// has fully drained.
//   CLK, ASYNC_RST, SYNC_RST      clock, async clear, sync clear (active-high)
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_addr, cmd_len             first row address, number of rows
//   busy, done                    run in progress / end-of-run pulse
//   brden, brdaddr, brddata       UB wide read port (1-cycle read latency)
//   sa_valid, sa_data             per-lane valid and skewed byte
// ---------------------------------------------------------------------------
module ub_skew_streamer
  import ub_pkg::*;
#(
  parameter  int SA_LENGTH  = 256,
  parameter  int ADDR_WIDTH = 10,
  parameter  int NO_BANKS   = 8,
  parameter  int LEN_WIDTH  = 16,
  localparam int UB_AW      = ADDR_WIDTH + $clog2(NO_BANKS)
) (
  input  logic                           CLK,
  input  logic                           ASYNC_RST,
  input  logic                           SYNC_RST,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [UB_AW-1:0]               cmd_addr,
  input  logic [LEN_WIDTH-1:0]           cmd_len,
  output logic                           busy,
  output logic                           done,
  output logic                           brden,
  output logic [UB_AW-1:0]               brdaddr,
  input  logic [UB_BYTE_W*SA_LENGTH-1:0] brddata,
  output logic [SA_LENGTH-1:0]           sa_valid,
  output logic [UB_BYTE_W*SA_LENGTH-1:0] sa_data
);

  // Drain must hold SA_LENGTH down to 0 inclusive.
  localparam int DRN_W = $clog2(SA_LENGTH + 1) + 1;

  ub_state_e            state_q, state_d;
  logic [UB_AW-1:0]     addr_q;
  logic [LEN_WIDTH-1:0] rem_q;
  logic [DRN_W-1:0]     drn_q;
  logic                 accept;
  logic                 rd_vld_p0;

  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST)     state_q <= ST_IDLE;
    else if (SYNC_RST) state_q <= ST_IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    brden     = 1'b0;
    accept    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          accept  = 1'b1;
          state_d = (cmd_len == '0) ? ST_DONE : ST_STREAM;
        end
      end
      ST_STREAM: begin
        brden = 1'b1;
        if (rem_q == LEN_WIDTH'(1)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drn_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Row address wraps naturally at 2^UB_AW; bank bits in the LSBs make
  // consecutive rows hit consecutive banks.
  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST) begin
      addr_q <= '0;
      rem_q  <= '0;
      drn_q  <= '0;
    end else if (SYNC_RST) begin
      addr_q <= '0;
      rem_q  <= '0;
      drn_q  <= '0;
    end else begin
      if (accept) begin
        addr_q <= cmd_addr;
        rem_q  <= cmd_len;
      end
      if (state_q == ST_STREAM) begin
        addr_q <= addr_q + UB_AW'(1);
        rem_q  <= rem_q - LEN_WIDTH'(1);
        // Drain covers the longest lane (SA_LENGTH-1 extra stages) plus the
        // UB read latency and the output register.
        drn_q  <= DRN_W'(SA_LENGTH);
      end
      if (state_q == ST_DRAIN) drn_q <= drn_q - DRN_W'(1);
    end
  end

  assign brdaddr = addr_q;

  // ---- p0: UB read data arrives, valid tracks the issued read ----
  always_ff @(posedge CLK or posedge ASYNC_RST) begin
    if (ASYNC_RST)     rd_vld_p0 <= 1'b0;
    else if (SYNC_RST) rd_vld_p0 <= 1'b0;
    else               rd_vld_p0 <= brden;
  end

  // ---- lane skew: lane i holds i+1 stages (capture + i delays, last is output) ----
  for (genvar i = 0; i < SA_LENGTH; i++) begin : g_lane
    ub_skew_line #(
      .DEPTH(i + 1)
    ) u_line (
      .CLK      (CLK),
      .ASYNC_RST(ASYNC_RST),
      .SYNC_RST (SYNC_RST),
      .in_vld   (rd_vld_p0),
      .in_data  (brddata[UB_BYTE_W*i +: UB_BYTE_W]),
      .out_vld  (sa_valid[i]),
      .out_data (sa_data[UB_BYTE_W*i +: UB_BYTE_W])
    );
  end

endmodule

// File: tb/tb_ub_skew_streamer.sv
// ---------------------------------------------------------------------------
// tb_ub_skew_streamer
// Scoreboard bench: each issued command pushes the expected read addresses,
// per-lane bytes (with their arrival cycles) and the done cycle; a monitor on
// the falling edge pops and compares every cycle.
// ---------------------------------------------------------------------------
module tb_ub_skew_streamer;

  localparam int SA    = 4;
  localparam int AW    = 3;
  localparam int NB    = 2;
  localparam int UAW   = 4;
  localparam int LW    = 16;
  localparam int NROWS = 16;

  logic             CLK = 1'b0;
  logic             ASYNC_RST = 1'b0;
  logic             SYNC_RST = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [UAW-1:0]   cmd_addr = '0;
  logic [LW-1:0]    cmd_len = '0;
  logic             busy, done, brden;
  logic [UAW-1:0]   brdaddr;
  logic [8*SA-1:0]  brddata;
  logic [SA-1:0]    sa_valid;
  logic [8*SA-1:0]  sa_data;

  ub_skew_streamer #(
    .SA_LENGTH(SA), .ADDR_WIDTH(AW), .NO_BANKS(NB), .LEN_WIDTH(LW)
  ) dut (
    .CLK(CLK), .ASYNC_RST(ASYNC_RST), .SYNC_RST(SYNC_RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .busy(busy), .done(done), .brden(brden), .brdaddr(brdaddr), .brddata(brddata),
    .sa_valid(sa_valid), .sa_data(sa_data)
  );

  always #5 CLK = ~CLK;

  // UB model: one-cycle read latency.
  logic [8*SA-1:0] mem [NROWS];
  always @(posedge CLK) if (brden) brddata <= mem[brdaddr];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  typedef struct { int c; logic [7:0] b; }     lev_t;
  typedef struct { int c; logic [UAW-1:0] a; } aev_t;
  lev_t lane_q [SA][$];
  aev_t rd_q[$];
  int   done_q[$];
  int   busy_lo = 1;
  int   busy_hi = 0;

  always @(negedge CLK) begin : monitor
    bit        ev, eb;
    logic [7:0] eb_val;
    if (mon_en) begin
      ev = (rd_q.size() > 0) && (rd_q[0].c == cyc);
      chk("brden", brden, ev);
      if (ev) begin
        chk("brdaddr", brdaddr, rd_q[0].a);
        void'(rd_q.pop_front());
      end
      ev = (done_q.size() > 0) && (done_q[0] == cyc);
      chk("done", done, ev);
      if (ev) void'(done_q.pop_front());
      eb = (cyc >= busy_lo) && (cyc <= busy_hi);
      chk("busy", busy, eb);
      chk("cmd_ready", cmd_ready, !eb);
      for (int i = 0; i < SA; i++) begin
        ev = (lane_q[i].size() > 0) && (lane_q[i][0].c == cyc);
        eb_val = ev ? lane_q[i][0].b : 8'h00;
        chk($sformatf("lane%0d_vld", i), sa_valid[i], ev);
        chk($sformatf("lane%0d_data", i), sa_data[8*i +: 8], eb_val);
        if (ev) void'(lane_q[i].pop_front());
      end
    end
  end

  function automatic bit sb_empty();
    bit e;
    e = (rd_q.size() == 0) && (done_q.size() == 0);
    for (int i = 0; i < SA; i++) e = e && (lane_q[i].size() == 0);
    return e;
  endfunction

  task automatic flush();
    rd_q.delete();
    done_q.delete();
    for (int i = 0; i < SA; i++) lane_q[i].delete();
    busy_lo = 1;
    busy_hi = 0;
  endtask

  // Called #1 after a rising edge; returns #1 after a rising edge.
  task automatic issue(input logic [UAW-1:0] addr, input int len, output int a);
    int g;
    int r;
    g = 0;
    while (!cmd_ready && g < 400) begin
      @(posedge CLK); #1;
      g++;
    end
    a = cyc;
    if (!cmd_ready) begin
      chk("issue_timeout", 1'b0, 1'b1);
      return;
    end
    cmd_addr  = addr;
    cmd_len   = LW'(len);
    cmd_valid = 1'b1;
    busy_lo   = a + 1;
    // Reference: row k read in a+1+k, byte i of that row on lane i at a+3+k+i.
    if (len == 0) begin
      busy_hi = a + 1;
      done_q.push_back(a + 1);
    end else begin
      for (int k = 0; k < len; k++) begin
        r = (int'(addr) + k) % NROWS;
        rd_q.push_back('{a + 1 + k, UAW'(r)});
        for (int i = 0; i < SA; i++)
          lane_q[i].push_back('{a + 3 + k + i, mem[r][8*i +: 8]});
      end
      busy_hi = a + len + SA + 2;
      done_q.push_back(a + len + SA + 2);
    end
    @(posedge CLK); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((!sb_empty() || cyc <= busy_hi) && g < 200) begin
      @(posedge CLK); #1;
      g++;
    end
    chk("drain_timeout", sb_empty(), 1'b1);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_brden"}, brden, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_sa_valid"}, sa_valid, '0);
    chk({tag, "_sa_data"}, sa_data, '0);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int a;
    for (int r = 0; r < NROWS; r++) mem[r] = $urandom;

    // Reset state
    #1 ASYNC_RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    check_idle_zero("rst");
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_brdaddr", brdaddr, '0);
    ASYNC_RST = 1'b0;
    @(posedge CLK); #1;
    mon_en = 1'b1;

    // Single row with known bytes
    mem[5] = 32'hA3A2_A1A0;
    issue(4'd5, 1, a);
    wait_drain();

    // Burst, wrap, empty command
    issue(4'd0, 3, a);
    wait_drain();
    issue(4'd15, 2, a);
    wait_drain();
    issue(4'd7, 0, a);
    wait_drain();

    // Commands offered while busy are ignored
    issue(4'd2, 4, a);
    cmd_addr  = 4'd9;
    cmd_len   = 16'd1;
    cmd_valid = 1'b1;
    repeat (5) begin
      chk("busy_cmd_ready", cmd_ready, 1'b0);
      @(posedge CLK); #1;
    end
    cmd_valid = 1'b0;
    wait_drain();

    // Async reset mid-stream
    issue(4'd0, 6, a);
    while (cyc < a + 4) begin @(posedge CLK); #1; end
    #2;
    mon_en = 1'b0;
    ASYNC_RST = 1'b1;
    #1;
    check_idle_zero("arst");
    @(posedge CLK); #2;
    ASYNC_RST = 1'b0;
    flush();
    @(posedge CLK); #1;
    chk("arst_cmd_ready", cmd_ready, 1'b1);
    chk("arst_busy", busy, 1'b0);
    mon_en = 1'b1;
    repeat (8) @(posedge CLK);
    #1;

    // Sync reset during drain
    issue(4'd3, 2, a);
    while (cyc < a + 4) begin @(posedge CLK); #1; end
    mon_en = 1'b0;
    SYNC_RST = 1'b1;
    @(posedge CLK); #1;
    SYNC_RST = 1'b0;
    check_idle_zero("srst");
    chk("srst_cmd_ready", cmd_ready, 1'b1);
    chk("srst_busy", busy, 1'b0);
    flush();
    mon_en = 1'b1;
    repeat (10) @(posedge CLK);
    #1;

    // Randomized runs
    for (int n = 0; n < 30; n++) begin
      for (int r = 0; r < NROWS; r++) mem[r] = $urandom;
      issue(UAW'($urandom_range(0, NROWS - 1)), int'($urandom_range(0, 7)), a);
      if ($urandom_range(0, 1) == 1) wait_drain();
      else begin
        wait_drain();
        repeat ($urandom_range(0, 3)) @(posedge CLK);
        #1;
      end
    end
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
